// File: rtl/pe_mslot.sv
// rtl/pe_mslot.sv - systolic PE with multi-slot weight store and 3-stage MAC
// Weights arrive by PE ID on a daisy-chained load bus; each pop consumes the next slot.
module pe_mslot #(
  parameter int ID_VAL         = 0,
  parameter int ID_WIDTH       = 6,
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 24,
  parameter int WGT_DEPTH      = 4,
  parameter int SIGNED_MODE    = 0,
  parameter int SAT_EN         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wgt_clr,
  input  logic                      i_load_vld,
  input  logic [ID_WIDTH-1:0]       i_load_id,
  input  logic [IN_DATA_WIDTH-1:0]  i_load_data,
  output logic                      o_load_vld,
  output logic [ID_WIDTH-1:0]       o_load_id,
  output logic [IN_DATA_WIDTH-1:0]  o_load_data,
  output logic                      o_wgt_full,
  input  logic                      i_pop_vld,
  input  logic [IN_DATA_WIDTH-1:0]  i_left_data,
  input  logic [OUT_DATA_WIDTH-1:0] i_up_data,
  output logic                      o_right_pop_vld,
  output logic [IN_DATA_WIDTH-1:0]  o_right_data,
  output logic                      o_down_vld,
  output logic [OUT_DATA_WIDTH-1:0] o_down_data,
  output logic                      o_sat
);
  localparam int IW = IN_DATA_WIDTH;
  localparam int OW = OUT_DATA_WIDTH;
  localparam int PW = $clog2(WGT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic SGN = (SIGNED_MODE != 0);

  logic [IW-1:0]     wgt_q [WGT_DEPTH];
  logic [IW-1:0]     wgt_d [WGT_DEPTH];
  logic [PW-1:0]     load_ptr_q, load_ptr_d, pop_ptr_q, pop_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              load_vld_q, load_vld_d;
  logic [ID_WIDTH-1:0] load_id_q, load_id_d;
  logic [IW-1:0]     load_data_q, load_data_d;
  logic              right_vld_q, right_vld_d;
  logic [IW-1:0]     right_data_q, right_data_d;
  logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [IW-1:0]     s1_left_q, s1_left_d, s1_wgt_q, s1_wgt_d;
  logic [OW-1:0]     s1_up_q, s1_up_d, s2_up_q, s2_up_d;
  logic [2*IW-1:0]   s2_prod_q, s2_prod_d;
  logic              down_vld_q, down_vld_d, sat_q, sat_d;
  logic [OW-1:0]     down_data_q, down_data_d;

  logic              hit, ovf;
  logic [2*IW-1:0]   left_x, wgt_x;
  logic [OW:0]       prod_x, up_x, sum;

  always_comb begin
    hit          = i_load_vld && (i_load_id == ID_WIDTH'(ID_VAL));
    wgt_d        = wgt_q;
    load_ptr_d   = load_ptr_q;
    pop_ptr_d    = pop_ptr_q;
    cnt_d        = cnt_q;
    if (i_wgt_clr) begin
      load_ptr_d = '0;
      pop_ptr_d  = '0;
      cnt_d      = '0;
    end else begin
      if (hit) begin
        wgt_d[load_ptr_q] = i_load_data;
        load_ptr_d        = load_ptr_q + PW'(1);
        if (cnt_q != CW'(WGT_DEPTH)) cnt_d = cnt_q + CW'(1);
      end
      if (i_pop_vld) pop_ptr_d = pop_ptr_q + PW'(1);
    end
    full_d       = (cnt_d == CW'(WGT_DEPTH));
    load_vld_d   = i_load_vld && !hit;
    load_id_d    = i_load_id;
    load_data_d  = i_load_data;
    right_vld_d  = i_pop_vld;
    right_data_d = i_left_data;

    // Stage 1 reads the pre-write slot contents, so a same-cycle load is not seen.
    s1_vld_d  = i_pop_vld;
    s1_left_d = i_left_data;
    s1_up_d   = i_up_data;
    s1_wgt_d  = wgt_q[pop_ptr_q];

    left_x    = {{IW{SGN & s1_left_q[IW-1]}}, s1_left_q};
    wgt_x     = {{IW{SGN & s1_wgt_q[IW-1]}}, s1_wgt_q};
    s2_vld_d  = s1_vld_q;
    s2_prod_d = left_x * wgt_x;
    s2_up_d   = s1_up_q;

    prod_x = {{(OW+1-2*IW){SGN & s2_prod_q[2*IW-1]}}, s2_prod_q};
    up_x   = {SGN & s2_up_q[OW-1], s2_up_q};
    sum    = prod_x + up_x;
    ovf    = SGN ? (sum[OW] != sum[OW-1]) : sum[OW];
    down_vld_d  = s2_vld_q;
    down_data_d = sum[OW-1:0];
    sat_d       = 1'b0;
    if ((SAT_EN != 0) && ovf) begin
      sat_d = s2_vld_q;
      if (SGN) down_data_d = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      else     down_data_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WGT_DEPTH; i++) wgt_q[i] <= '0;
      load_ptr_q   <= '0;
      pop_ptr_q    <= '0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      load_vld_q   <= 1'b0;
      load_id_q    <= '0;
      load_data_q  <= '0;
      right_vld_q  <= 1'b0;
      right_data_q <= '0;
      s1_vld_q     <= 1'b0;
      s1_left_q    <= '0;
      s1_up_q      <= '0;
      s1_wgt_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_prod_q    <= '0;
      s2_up_q      <= '0;
      down_vld_q   <= 1'b0;
      down_data_q  <= '0;
      sat_q        <= 1'b0;
    end else begin
      wgt_q        <= wgt_d;
      load_ptr_q   <= load_ptr_d;
      pop_ptr_q    <= pop_ptr_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      load_vld_q   <= load_vld_d;
      load_id_q    <= load_id_d;
      load_data_q  <= load_data_d;
      right_vld_q  <= right_vld_d;
      right_data_q <= right_data_d;
      s1_vld_q     <= s1_vld_d;
      s1_left_q    <= s1_left_d;
      s1_up_q      <= s1_up_d;
      s1_wgt_q     <= s1_wgt_d;
      s2_vld_q     <= s2_vld_d;
      s2_prod_q    <= s2_prod_d;
      s2_up_q      <= s2_up_d;
      down_vld_q   <= down_vld_d;
      down_data_q  <= down_data_d;
      sat_q        <= sat_d;
    end
  end

  assign o_load_vld      = load_vld_q;
  assign o_load_id       = load_id_q;
  assign o_load_data     = load_data_q;
  assign o_wgt_full      = full_q;
  assign o_right_pop_vld = right_vld_q;
  assign o_right_data    = right_data_q;
  assign o_down_vld      = down_vld_q;
  assign o_down_data     = down_data_q;
  assign o_sat           = sat_q;
endmodule

// File: tb/tb_pe_mslot.sv
// tb/tb_pe_mslot.sv - bench for pe_mslot across unsigned, signed and saturating builds
// Shared load bus and operands; per-instance pop enables steer which PE issues.
module tb_pe_mslot;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wgt_clr = 0, load_vld = 0, pop = 0;
  logic [5:0]  load_id = 0;
  logic [7:0]  load_data = 0, left = 0;
  logic [3:0]  en = 0;
  logic [23:0] up = 0;

  logic        lv [4], full [4], rpv [4], dv [4], sat [4];
  logic [5:0]  lid [4];
  logic [7:0]  ld [4], rd [4];
  logic [23:0] dd0, dd1;
  logic [15:0] dd2, dd3;

  int tests = 0, fails = 0;
  logic [24:0] sbq [4][$];

  pe_mslot #(.ID_VAL(5)) u0 (
    .clk(clk), .rst(rst), .i_wgt_clr(wgt_clr), .i_load_vld(load_vld), .i_load_id(load_id),
    .i_load_data(load_data), .o_load_vld(lv[0]), .o_load_id(lid[0]), .o_load_data(ld[0]),
    .o_wgt_full(full[0]), .i_pop_vld(pop & en[0]), .i_left_data(left), .i_up_data(up),
    .o_right_pop_vld(rpv[0]), .o_right_data(rd[0]), .o_down_vld(dv[0]), .o_down_data(dd0),
    .o_sat(sat[0]));
  pe_mslot #(.ID_VAL(5), .SIGNED_MODE(1)) u1 (
    .clk(clk), .rst(rst), .i_wgt_clr(wgt_clr), .i_load_vld(load_vld), .i_load_id(load_id),
    .i_load_data(load_data), .o_load_vld(lv[1]), .o_load_id(lid[1]), .o_load_data(ld[1]),
    .o_wgt_full(full[1]), .i_pop_vld(pop & en[1]), .i_left_data(left), .i_up_data(up),
    .o_right_pop_vld(rpv[1]), .o_right_data(rd[1]), .o_down_vld(dv[1]), .o_down_data(dd1),
    .o_sat(sat[1]));
  pe_mslot #(.ID_VAL(5), .OUT_DATA_WIDTH(16), .SAT_EN(1)) u2 (
    .clk(clk), .rst(rst), .i_wgt_clr(wgt_clr), .i_load_vld(load_vld), .i_load_id(load_id),
    .i_load_data(load_data), .o_load_vld(lv[2]), .o_load_id(lid[2]), .o_load_data(ld[2]),
    .o_wgt_full(full[2]), .i_pop_vld(pop & en[2]), .i_left_data(left), .i_up_data(up[15:0]),
    .o_right_pop_vld(rpv[2]), .o_right_data(rd[2]), .o_down_vld(dv[2]), .o_down_data(dd2),
    .o_sat(sat[2]));
  pe_mslot #(.ID_VAL(5), .OUT_DATA_WIDTH(16), .SAT_EN(0)) u3 (
    .clk(clk), .rst(rst), .i_wgt_clr(wgt_clr), .i_load_vld(load_vld), .i_load_id(load_id),
    .i_load_data(load_data), .o_load_vld(lv[3]), .o_load_id(lid[3]), .o_load_data(ld[3]),
    .o_wgt_full(full[3]), .i_pop_vld(pop & en[3]), .i_left_data(left), .i_up_data(up[15:0]),
    .o_right_pop_vld(rpv[3]), .o_right_data(rd[3]), .o_down_vld(dv[3]), .o_down_data(dd3),
    .o_sat(sat[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [23:0] d, input logic s);
    logic [24:0] e;
    if (v === 1'b1) begin
      if (sbq[k].size() == 0) begin
        check($sformatf("spurious_down_vld_u%0d", k), 32'(v), 32'd0);
      end else begin
        e = sbq[k].pop_front();
        check($sformatf("down_u%0d", k), {7'd0, s, d}, {7'd0, e});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, dv[0], dd0, sat[0]);
      mon(1, dv[1], dd1, sat[1]);
      mon(2, dv[2], {8'd0, dd2}, sat[2]);
      mon(3, dv[3], {8'd0, dd3}, sat[3]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] id, input logic [7:0] d);
    load_vld = 1; load_id = id; load_data = d;
    step();
    load_vld = 0;
  endtask

  task automatic issue(input logic [3:0] e, input logic [7:0] l, input logic [23:0] u);
    pop = 1; en = e; left = l; up = u;
    step();
    pop = 0;
  endtask

  task automatic clr();
    wgt_clr = 1;
    step();
    wgt_clr = 0;
  endtask

  task automatic drain(input string tag);
    repeat (5) step();
    for (int k = 0; k < 4; k++) check($sformatf("%s_q%0d_empty", tag, k), 32'(sbq[k].size()), 32'd0);
  endtask

  initial begin
    repeat (2) step();
    check("rst_load_vld", 32'(lv[0]), 32'd0);
    check("rst_full", 32'(full[0]), 32'd0);
    check("rst_down_vld", 32'(dv[0]), 32'd0);
    check("rst_down_data", 32'(dd0), 32'd0);
    check("rst_right_vld", 32'(rpv[0]), 32'd0);
    check("rst_sat", 32'(sat[2]), 32'd0);
    rst = 0;
    step();

    // T1 load and forwarding
    beat(6'd5, 8'd3);
    check("t1_hit_consumed", 32'(lv[0]), 32'd0);
    beat(6'd5, 8'd5);
    beat(6'd5, 8'd7);
    check("t1_not_full_3", 32'(full[0]), 32'd0);
    beat(6'd5, 8'd9);
    check("t1_hit4_consumed", 32'(lv[0]), 32'd0);
    check("t1_full_4", 32'(full[0]), 32'd1);
    beat(6'd2, 8'h44);
    check("t1_fwd_vld", 32'(lv[0]), 32'd1);
    check("t1_fwd_id", 32'(lid[0]), 32'd2);
    check("t1_fwd_data", 32'(ld[0]), 32'h44);
    step();
    check("t1_fwd_drop", 32'(lv[0]), 32'd0);

    // T2 back-to-back unsigned pops with wrap
    sbq[0].push_back(25'd16); issue(4'b0001, 8'd2, 24'd10);
    check("t2_right_vld", 32'(rpv[0]), 32'd1);
    check("t2_right_data", 32'(rd[0]), 32'd2);
    sbq[0].push_back(25'd20); issue(4'b0001, 8'd2, 24'd10);
    sbq[0].push_back(25'd24); issue(4'b0001, 8'd2, 24'd10);
    sbq[0].push_back(25'd28); issue(4'b0001, 8'd2, 24'd10);
    sbq[0].push_back(25'd16); issue(4'b0001, 8'd2, 24'd10);
    drain("t2");
    check("t2_right_idle", 32'(rpv[0]), 32'd0);

    // T5 same-slot load and pop: pop sees old value
    clr();
    check("t5_clr_full", 32'(full[0]), 32'd0);
    load_vld = 1; load_id = 6'd5; load_data = 8'd11;
    sbq[0].push_back(25'd3);
    issue(4'b0001, 8'd1, 24'd0);
    load_vld = 0;
    check("t5_cnt1_not_full", 32'(full[0]), 32'd0);
    sbq[0].push_back(25'd5);  issue(4'b0001, 8'd1, 24'd0);
    sbq[0].push_back(25'd7);  issue(4'b0001, 8'd1, 24'd0);
    sbq[0].push_back(25'd9);  issue(4'b0001, 8'd1, 24'd0);
    sbq[0].push_back(25'd11); issue(4'b0001, 8'd1, 24'd0);

    // clear with simultaneous hit: consumed, not stored
    wgt_clr = 1; load_vld = 1; load_id = 6'd5; load_data = 8'h77;
    step();
    wgt_clr = 0; load_vld = 0;
    check("clrhit_not_fwd", 32'(lv[0]), 32'd0);
    check("clrhit_full", 32'(full[0]), 32'd0);
    sbq[0].push_back(25'd11); issue(4'b0001, 8'd1, 24'd0);
    drain("t5");

    // T3 signed: slots FD,5,7,9
    clr();
    beat(6'd5, 8'hFD);
    sbq[1].push_back({1'b0, 24'hFFFFF8}); issue(4'b0010, 8'hFC, 24'hFFFFEC);
    sbq[1].push_back({1'b0, 24'hFFFD80}); issue(4'b0010, 8'h80, 24'd0);
    drain("t3");

    // T4 saturation vs wrap at OUT=16: slots FF,5,7,9
    clr();
    beat(6'd5, 8'hFF);
    sbq[2].push_back({1'b1, 8'd0, 16'hFFFF});
    sbq[3].push_back({1'b0, 8'd0, 16'hFE00});
    issue(4'b1100, 8'hFF, 24'h00FFFF);
    sbq[2].push_back({1'b0, 8'd0, 16'h001A});
    sbq[3].push_back({1'b0, 8'd0, 16'h001A});
    issue(4'b1100, 8'd2, 24'h000010);
    drain("t4");

    // T6 async reset mid-pipeline and mid-load
    beat(6'd5, 8'd20); beat(6'd5, 8'd21); beat(6'd5, 8'd22); beat(6'd5, 8'd23);
    check("t6_full_before", 32'(full[0]), 32'd1);
    pop = 1; en = 4'b0001; left = 8'd1; up = 24'd0;
    load_vld = 1; load_id = 6'd2; load_data = 8'h55;
    step();
    pop = 0; load_vld = 0;
    check("t6_right_vld_pre", 32'(rpv[0]), 32'd1);
    check("t6_fwd_vld_pre", 32'(lv[0]), 32'd1);
    rst = 1;
    #1;
    check("t6_right_vld_rst", 32'(rpv[0]), 32'd0);
    check("t6_fwd_vld_rst", 32'(lv[0]), 32'd0);
    check("t6_full_rst", 32'(full[0]), 32'd0);
    repeat (2) step();
    rst = 0;
    step();
    check("t6_full_after", 32'(full[0]), 32'd0);
    check("t6_down_vld_after", 32'(dv[0]), 32'd0);
    beat(6'd5, 8'd6);
    sbq[0].push_back(25'd6); issue(4'b0001, 8'd1, 24'd0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
